// File: rtl/traffic_conflict_monitor.sv
`default_nettype none
// ============================================================================
// Module  : traffic_conflict_monitor
// Brief   : Safety stage behind the 4-way light sequencer; passes lamp codes
//           through and forces flashing red on any illegal or unsafe pattern.
// Rev     : 1.0  initial release
// ============================================================================
module traffic_conflict_monitor #(
  parameter int MIN_YEL    = 4,
  parameter int MAX_GRN    = 16,
  parameter int FLASH_HALF = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] north_i,
  input  logic [2:0] south_i,
  input  logic [2:0] east_i,
  input  logic [2:0] west_i,
  input  logic       fault_clr_i,
  output logic [2:0] north_o,
  output logic [2:0] south_o,
  output logic [2:0] east_o,
  output logic [2:0] west_o,
  output logic       fault_o,
  output logic [2:0] fault_code_o,
  output logic       flash_on_o
);

  localparam int DW  = $clog2(MAX_GRN + 2);
  localparam int FCW = $clog2(FLASH_HALF + 1);

  localparam logic [2:0]     c_RED        = 3'b100;
  localparam logic [2:0]     c_YEL        = 3'b010;
  localparam logic [2:0]     c_GRN        = 3'b001;
  localparam logic [2:0]     c_OFF        = 3'b000;
  localparam logic [DW-1:0]  c_DWELL_SAT  = DW'(MAX_GRN + 1);
  localparam logic [DW-1:0]  c_DWELL_ONE  = DW'(1);
  localparam logic [DW-1:0]  c_MIN_YEL    = DW'(MIN_YEL);
  localparam logic [DW-1:0]  c_MAX_GRN    = DW'(MAX_GRN);
  localparam logic [FCW-1:0] c_FLASH_LAST = FCW'(FLASH_HALF - 1);
  localparam logic [FCW-1:0] c_FCNT_ONE   = FCW'(1);

  typedef enum logic [1:0] {
    ST_MONITOR = 2'd0,
    ST_FAULT   = 2'd1,
    ST_RESYNC  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [2:0]     out_q   [4];
  logic [2:0]     out_d   [4];
  logic [2:0]     prev_q  [4];
  logic [2:0]     prev_d  [4];
  logic [DW-1:0]  dwell_q [4];
  logic [DW-1:0]  dwell_d [4];
  logic           fault_q, fault_d;
  logic           flash_q, flash_d;
  logic [2:0]     code_q, code_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;

  logic [2:0]     w_in        [4];
  logic [DW-1:0]  w_dwell_inc [4];
  logic           w_invalid, w_conflict, w_badtr, w_short, w_long, w_exit;
  logic [2:0]     w_nonred_cnt, w_red_cnt, w_launch_cnt, w_code;

  assign w_in[0] = north_i;
  assign w_in[1] = south_i;
  assign w_in[2] = east_i;
  assign w_in[3] = west_i;

  // Per-approach violation detection and resync-exit qualification.
  always_comb begin
    w_invalid    = 1'b0;
    w_badtr      = 1'b0;
    w_short      = 1'b0;
    w_long       = 1'b0;
    w_nonred_cnt = 3'd0;
    w_red_cnt    = 3'd0;
    w_launch_cnt = 3'd0;
    for (int i = 0; i < 4; i++) begin
      w_dwell_inc[i] = c_DWELL_ONE;
      if (w_in[i] == prev_q[i])
        w_dwell_inc[i] = (dwell_q[i] == c_DWELL_SAT) ? c_DWELL_SAT : dwell_q[i] + c_DWELL_ONE;
      if (w_in[i] != c_RED && w_in[i] != c_YEL && w_in[i] != c_GRN)
        w_invalid = 1'b1;
      if (w_in[i] != c_RED)
        w_nonred_cnt = w_nonred_cnt + 3'd1;
      else
        w_red_cnt = w_red_cnt + 3'd1;
      if ((prev_q[i] == c_GRN && w_in[i] == c_RED) ||
          (prev_q[i] == c_RED && w_in[i] == c_YEL) ||
          (prev_q[i] == c_YEL && w_in[i] == c_GRN))
        w_badtr = 1'b1;
      if (prev_q[i] == c_YEL && w_in[i] == c_RED && dwell_q[i] < c_MIN_YEL)
        w_short = 1'b1;
      // This sample would be green dwell number dwell_q+1.
      if (prev_q[i] == c_GRN && w_in[i] == c_GRN && dwell_q[i] >= c_MAX_GRN)
        w_long = 1'b1;
      if (prev_q[i] == c_RED && w_in[i] == c_GRN)
        w_launch_cnt = w_launch_cnt + 3'd1;
    end
    w_conflict = (w_nonred_cnt > 3'd1);
    w_exit     = (w_launch_cnt == 3'd1) && (w_red_cnt == 3'd3);
    if (w_invalid)       w_code = 3'd1;
    else if (w_conflict) w_code = 3'd2;
    else if (w_badtr)    w_code = 3'd3;
    else if (w_short)    w_code = 3'd4;
    else if (w_long)     w_code = 3'd5;
    else                 w_code = 3'd0;
  end

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    code_d  = code_q;
    flash_d = flash_q;
    fcnt_d  = fcnt_q;
    for (int i = 0; i < 4; i++) begin
      out_d[i]   = out_q[i];
      prev_d[i]  = w_in[i];
      dwell_d[i] = dwell_q[i];
    end
    case (state_q)
      ST_MONITOR: begin
        if (w_code != 3'd0) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
          code_d  = w_code;
          flash_d = 1'b1;
          fcnt_d  = '0;
          for (int i = 0; i < 4; i++) out_d[i] = c_RED;
        end else begin
          for (int i = 0; i < 4; i++) begin
            out_d[i]   = w_in[i];
            dwell_d[i] = w_dwell_inc[i];
          end
        end
      end
      ST_FAULT: begin
        if (fault_clr_i) begin
          state_d = ST_RESYNC;
          flash_d = 1'b0;
          fcnt_d  = '0;
          for (int i = 0; i < 4; i++) out_d[i] = c_RED;
        end else begin
          if (fcnt_q == c_FLASH_LAST) begin
            flash_d = ~flash_q;
            fcnt_d  = '0;
          end else begin
            fcnt_d  = fcnt_q + c_FCNT_ONE;
          end
          for (int i = 0; i < 4; i++) out_d[i] = flash_d ? c_RED : c_OFF;
        end
      end
      ST_RESYNC: begin
        for (int i = 0; i < 4; i++) out_d[i] = c_RED;
        if (w_exit) begin
          state_d = ST_MONITOR;
          fault_d = 1'b0;
          code_d  = 3'd0;
          for (int i = 0; i < 4; i++) begin
            out_d[i]   = w_in[i];
            dwell_d[i] = c_DWELL_ONE;
          end
        end
      end
      default: state_d = ST_MONITOR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_MONITOR;
      fault_q <= 1'b0;
      code_q  <= 3'd0;
      flash_q <= 1'b0;
      fcnt_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        out_q[i]   <= c_RED;
        prev_q[i]  <= c_RED;
        dwell_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      flash_q <= flash_d;
      fcnt_q  <= fcnt_d;
      for (int i = 0; i < 4; i++) begin
        out_q[i]   <= out_d[i];
        prev_q[i]  <= prev_d[i];
        dwell_q[i] <= dwell_d[i];
      end
    end
  end

  assign north_o      = out_q[0];
  assign south_o      = out_q[1];
  assign east_o       = out_q[2];
  assign west_o       = out_q[3];
  assign fault_o      = fault_q;
  assign fault_code_o = code_q;
  assign flash_on_o   = flash_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_conflict_monitor.sv
`default_nettype none
// ============================================================================
// Module  : tb_traffic_conflict_monitor
// Brief   : Directed scoreboard bench for traffic_conflict_monitor.
// Rev     : 1.0  initial release
// ============================================================================
module tb_traffic_conflict_monitor;

  localparam logic [2:0]  R = 3'b100;
  localparam logic [2:0]  Y = 3'b010;
  localparam logic [2:0]  G = 3'b001;
  localparam logic [11:0] ALL_RED = 12'o4444;
  localparam logic [11:0] ALL_OFF = 12'o0000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] north_i = R, south_i = R, east_i = R, west_i = R;
  logic       fault_clr_i = 1'b0;
  logic [2:0] north_o, south_o, east_o, west_o, fault_code_o;
  logic       fault_o, flash_on_o;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [11:0] outs;
    logic        fault;
    logic [2:0]  code;
    logic        flash;
    logic        flash_chk;
    string       nm;
  } exp_t;

  exp_t exp_q[$];

  traffic_conflict_monitor dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .north_i      (north_i),
    .south_i      (south_i),
    .east_i       (east_i),
    .west_i       (west_i),
    .fault_clr_i  (fault_clr_i),
    .north_o      (north_o),
    .south_o      (south_o),
    .east_o       (east_o),
    .west_o       (west_o),
    .fault_o      (fault_o),
    .fault_code_o (fault_code_o),
    .flash_on_o   (flash_on_o)
  );

  always #5 clk = ~clk;

  function automatic void compare(input string nm, input logic [11:0] xo, input logic xf,
                                  input logic [2:0] xc, input logic xfl, input logic fchk);
    logic [11:0] act;
    act = {north_o, south_o, east_o, west_o};
    n_checks++;
    if (act == xo && fault_o == xf && fault_code_o == xc && (!fchk || flash_on_o == xfl))
      n_pass++;
    else
      $display("FAIL %s @%0t: got out=%o fault=%b code=%0d flash=%b, want out=%o fault=%b code=%0d flash=%b",
               nm, $time, act, fault_o, fault_code_o, flash_on_o, xo, xf, xc, xfl);
  endfunction

  // Monitor: one expected record per clock edge that the driver announced.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compare(e.nm, e.outs, e.fault, e.code, e.flash, e.flash_chk);
    end
  end

  task automatic step(input logic [2:0] nn, ss, ee, ww, input logic c,
                      input logic [11:0] xo, input logic xf, input logic [2:0] xc,
                      input logic xfl, input logic fchk, input string nm);
    exp_t e;
    @(negedge clk);
    north_i = nn; south_i = ss; east_i = ee; west_i = ww; fault_clr_i = c;
    e.outs = xo; e.fault = xf; e.code = xc; e.flash = xfl; e.flash_chk = fchk; e.nm = nm;
    exp_q.push_back(e);
  endtask

  // Nominal upstream cycle: N,S,E,W each green 8 then yellow 4.
  function automatic logic [2:0] lamp(input int t, input int a);
    int ph;
    ph = t % 48;
    if (ph / 12 != a) return R;
    return (ph % 12 < 8) ? G : Y;
  endfunction

  task automatic nom(input int t);
    logic [2:0] n, s, e, w;
    n = lamp(t, 0); s = lamp(t, 1); e = lamp(t, 2); w = lamp(t, 3);
    step(n, s, e, w, 1'b0, {n, s, e, w}, 1'b0, 3'd0, 1'b0, 1'b1, "nominal");
  endtask

  // i-th edge after fault entry: red for edges 0..3, off for 4..7, and so on.
  task automatic flash_hold(input int n, input logic [2:0] code);
    logic fl;
    for (int i = 1; i <= n; i++) begin
      fl = ((i / 4) % 2) == 0;
      step(R, R, R, R, 1'b0, fl ? ALL_RED : ALL_OFF, 1'b1, code, fl, 1'b1, "flash");
    end
  endtask

  task automatic recover(input logic [2:0] code);
    step(R, R, R, R, 1'b1, ALL_RED, 1'b1, code, 1'b0, 1'b0, "clear");
    step(G, R, G, R, 1'b0, ALL_RED, 1'b1, code, 1'b0, 1'b0, "resync_two_green");
    step(R, R, R, R, 1'b1, ALL_RED, 1'b1, code, 1'b0, 1'b0, "resync_red");
    step(G, R, R, R, 1'b0, 12'o1444, 1'b0, 3'd0, 1'b0, 1'b1, "resync_exit");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    #2 compare("reset_state", ALL_RED, 1'b0, 3'd0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 300; t++) nom(t);

    // Conflict: north and east green together.
    step(R, R, R, R, 1'b0, ALL_RED, 1'b0, 3'd0, 1'b0, 1'b1, "all_red");
    step(G, R, G, R, 1'b0, ALL_RED, 1'b1, 3'd2, 1'b1, 1'b1, "conflict");
    flash_hold(11, 3'd2);
    recover(3'd2);

    // Green straight to red; fault_clr must be ignored while monitoring.
    step(G, R, R, R, 1'b1, 12'o1444, 1'b0, 3'd0, 1'b0, 1'b1, "clr_ignored");
    step(R, R, R, R, 1'b0, ALL_RED, 1'b1, 3'd3, 1'b1, 1'b1, "green_to_red");
    flash_hold(2, 3'd3);
    recover(3'd3);

    // Yellow held only two cycles.
    step(G, R, R, R, 1'b0, 12'o1444, 1'b0, 3'd0, 1'b0, 1'b1, "green");
    step(Y, R, R, R, 1'b0, 12'o2444, 1'b0, 3'd0, 1'b0, 1'b1, "yellow1");
    step(Y, R, R, R, 1'b0, 12'o2444, 1'b0, 3'd0, 1'b0, 1'b1, "yellow2");
    step(R, R, R, R, 1'b0, ALL_RED, 1'b1, 3'd4, 1'b1, 1'b1, "short_yellow");
    recover(3'd4);

    // Long green: exit sample is green #1, #2..#16 legal, #17 faults.
    for (int i = 2; i <= 16; i++)
      step(G, R, R, R, 1'b0, 12'o1444, 1'b0, 3'd0, 1'b0, 1'b1, "green_dwell");
    step(G, R, R, R, 1'b0, ALL_RED, 1'b1, 3'd5, 1'b1, 1'b1, "long_green");
    recover(3'd5);

    // Same long green with an invalid west code: invalid has priority.
    for (int i = 2; i <= 16; i++)
      step(G, R, R, R, 1'b0, 12'o1444, 1'b0, 3'd0, 1'b0, 1'b1, "green_dwell");
    step(G, R, R, 3'b011, 1'b0, ALL_RED, 1'b1, 3'd1, 1'b1, 1'b1, "invalid_priority");
    flash_hold(5, 3'd1);

    // Asynchronous reset during the dark half of the flash.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 compare("async_reset", ALL_RED, 1'b0, 3'd0, 1'b0, 1'b1);
    @(negedge clk);
    compare("reset_hold", ALL_RED, 1'b0, 3'd0, 1'b0, 1'b1);
    north_i = R; south_i = R; east_i = R; west_i = R; fault_clr_i = 1'b0;
    rst_n = 1'b1;
    for (int t = 0; t < 60; t++) nom(t);

    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending records, want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
